// File: rtl/color_freq_meter.sv
// Colour sensor frequency meter: counts rising edges of the sensor output
// over a fixed gate window and auto-ranges the sensor S0/S1 scaling so the
// published count stays between the low and high thresholds.
module color_freq_meter #(
    parameter int unsigned GATE_CYCLES   = 100000,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter logic [15:0] HI_THRESH     = 16'd40000,
    parameter logic [15:0] LO_THRESH     = 16'd400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sensorFreq,
    output logic [1:0]  scale,
    output logic [15:0] freq_count,
    output logic [1:0]  freq_scale,
    output logic        freq_valid,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        EVAL    = 2'd3
    } state_t;

    localparam logic [1:0] SCALE_OFF  = 2'b00;
    localparam logic [1:0] SCALE_2    = 2'b01;
    localparam logic [1:0] SCALE_100  = 2'b11;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  scale_next;
    logic        publish;
    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic        edge_det;
    logic [31:0] settle_cnt;
    logic [31:0] window_cnt;
    logic [15:0] edge_cnt;

    // The third flop only exists to delay sync2 so a rising edge is a single-cycle pulse.
    assign edge_det = sync2 & ~sync3;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, auto-ranging decision and publish strobe; enable low overrides everything.
    always_comb begin
        state_next = state;
        scale_next = scale;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                scale_next = SCALE_OFF;
                if (enable) begin
                    state_next = SETTLE;
                    scale_next = SCALE_100;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (window_cnt == GATE_LAST) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if ((edge_cnt > HI_THRESH) && (scale != SCALE_2)) begin
                    scale_next = scale - 2'd1;
                    state_next = SETTLE;
                end else if ((edge_cnt < LO_THRESH) && (scale != SCALE_100)) begin
                    scale_next = scale + 2'd1;
                    state_next = SETTLE;
                end else begin
                    publish    = 1'b1;
                    state_next = MEASURE;
                end
            end
            default: begin
                state_next = IDLE;
                scale_next = SCALE_OFF;
            end
        endcase
        if (!enable) begin
            state_next = IDLE;
            scale_next = SCALE_OFF;
            publish    = 1'b0;
        end
    end

    // Synchroniser, counters and output registers; counters clear whenever their state is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            settle_cnt <= '0;
            window_cnt <= '0;
            edge_cnt   <= '0;
            scale      <= SCALE_OFF;
            freq_count <= '0;
            freq_scale <= SCALE_100;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync1      <= sensorFreq;
            sync2      <= sync1;
            sync3      <= sync2;
            scale      <= scale_next;
            freq_valid <= publish;

            if (state == SETTLE && enable) begin
                settle_cnt <= settle_cnt + 32'd1;
            end else begin
                settle_cnt <= '0;
            end

            if (state == MEASURE && enable) begin
                window_cnt <= window_cnt + 32'd1;
                if (edge_det && (edge_cnt != 16'hFFFF)) begin
                    edge_cnt <= edge_cnt + 16'd1;
                end
            end else begin
                window_cnt <= '0;
                edge_cnt   <= '0;
            end

            if (publish) begin
                freq_count <= edge_cnt;
                freq_scale <= scale;
                if ((edge_cnt == 16'hFFFF) && (scale == SCALE_2)) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
